// File: rtl/cla_addsub_pipe.sv
// ============================================================================
// Module   : cla_addsub_pipe
// Brief    : Two-stage pipelined carry-lookahead adder/subtractor with
//            elastic valid/ready handshake on both sides.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cla_addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int C_NGRP = WIDTH / GROUP;

    // Stage 1 registers
    logic              s1_valid_q;
    logic [WIDTH-1:0]  p_q, g_q;
    logic [C_NGRP-1:0] gg_q, pp_q;
    logic              cin_q, a_msb_q, bb_msb_q;

    // Stage 1 next-state
    logic [WIDTH-1:0]  bb_d, p_d, g_d;
    logic [C_NGRP-1:0] gg_d, pp_d;

    // Stage 2 next-state and carry network
    logic [C_NGRP:0]   grp_c;
    logic [WIDTH:0]    bit_c;
    logic [WIDTH-1:0]  sum_d;
    logic              ovf_d;

    logic              s2_adv;

    assign s2_adv   = s1_valid_q & (~out_valid | out_ready);
    assign in_ready = ~s1_valid_q | s2_adv;

    assign bb_d = sub ? ~b : b;
    assign p_d  = a ^ bb_d;
    assign g_d  = a & bb_d;

    // Group generate folds from LSB upward: GG = g[n] | p[n] & GG(below)
    always_comb begin
        gg_d = '0;
        pp_d = '0;
        for (int k = 0; k < C_NGRP; k++) begin
            for (int j = 0; j < GROUP; j++) begin
                gg_d[k] = g_d[k*GROUP+j] | (p_d[k*GROUP+j] & gg_d[k]);
            end
            pp_d[k] = &p_d[k*GROUP +: GROUP];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            p_q        <= '0;
            g_q        <= '0;
            gg_q       <= '0;
            pp_q       <= '0;
            cin_q      <= 1'b0;
            a_msb_q    <= 1'b0;
            bb_msb_q   <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                p_q      <= p_d;
                g_q      <= g_d;
                gg_q     <= gg_d;
                pp_q     <= pp_d;
                cin_q    <= sub;
                a_msb_q  <= a[WIDTH-1];
                bb_msb_q <= bb_d[WIDTH-1];
            end
        end
    end

    // Group carries by lookahead, then bit carries seeded from each group carry
    always_comb begin
        grp_c    = '0;
        bit_c    = '0;
        grp_c[0] = cin_q;
        for (int k = 0; k < C_NGRP; k++) begin
            grp_c[k+1] = gg_q[k] | (pp_q[k] & grp_c[k]);
        end
        for (int k = 0; k < C_NGRP; k++) begin
            bit_c[k*GROUP] = grp_c[k];
            for (int j = 0; j < GROUP - 1; j++) begin
                bit_c[k*GROUP+j+1] = g_q[k*GROUP+j] | (p_q[k*GROUP+j] & bit_c[k*GROUP+j]);
            end
        end
        bit_c[WIDTH] = grp_c[C_NGRP];
    end

    assign sum_d = p_q ^ bit_c[WIDTH-1:0];
    assign ovf_d = (a_msb_q == bb_msb_q) & (sum_d[WIDTH-1] != a_msb_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= 1'b1;
            sum       <= sum_d;
            cout      <= bit_c[WIDTH];
            ovf       <= ovf_d;
            zero      <= ~|sum_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cla_addsub_pipe.sv
// ============================================================================
// Module   : tb_cla_addsub_pipe
// Brief    : Scoreboard bench for cla_addsub_pipe (WIDTH=32, GROUP=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cla_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout, ovf, zero;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    logic [34:0] sb[$];

    cla_addsub_pipe #(.WIDTH(32), .GROUP(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    // {sum, cout, ovf, zero}
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [32:0] r;
        logic        v;
        if (s) begin
            r = {1'b0, x} + {1'b0, ~y} + 33'd1;
            v = (x[31] != y[31]) && (r[31] != x[31]);
        end else begin
            r = {1'b0, x} + {1'b0, y};
            v = (x[31] == y[31]) && (r[31] != x[31]);
        end
        return {r[31:0], r[32], v, (r[31:0] == 32'd0)};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_checks++;
                n_out++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got sum=%h cout=%b ovf=%b zero=%b, expected no output",
                             sum, cout, ovf, zero);
                end else begin
                    logic [34:0] e;
                    e = sb.pop_front();
                    if ({sum, cout, ovf, zero} !== e) begin
                        n_fail++;
                        $display("FAIL sb_result: got sum=%h c=%b v=%b z=%b, expected sum=%h c=%b v=%b z=%b",
                                 sum, cout, ovf, zero, e[34:3], e[2], e[1], e[0]);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(a, b, sub));
        end
    end

    task automatic drain(input int max_cyc);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        a = 32'd5; b = 32'd3; sub = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        n_checks++;
        if ({out_valid, sum, cout, ovf, zero} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_state: got ov=%b sum=%h c=%b v=%b z=%b, expected all zero",
                     out_valid, sum, cout, ovf, zero);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [31:0] va[4]   = '{32'h5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h3};
        logic [31:0] vb[4]   = '{32'h3, 32'h1, 32'h1, 32'h5};
        logic        vs[4]   = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [34:0] vexp[4] = '{{32'h8, 3'b000}, {32'h0, 3'b101},
                                 {32'h7FFF_FFFF, 3'b110}, {32'hFFFF_FFFE, 3'b000}};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a = va[i]; b = vb[i]; sub = vs[i];
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(posedge clk); #1;
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || {sum, cout, ovf, zero} !== vexp[i]) begin
                n_fail++;
                $display("FAIL directed_%0d: got ov=%b sum=%h c=%b v=%b z=%b, expected ov=1 sum=%h c=%b v=%b z=%b",
                         i, out_valid, sum, cout, ovf, zero, vexp[i][34:3], vexp[i][2], vexp[i][1], vexp[i][0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom; sub = i[0];
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_in_ready_%0d: got %b, expected 1", i, in_ready);
            end
            @(posedge clk); #1;
        end
        drain(20);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_backpressure;
        int idx = 0;
        int out0 = n_out;
        in_valid = 1'b1; a = $urandom; b = $urandom; sub = 1'b1;
        for (int c = 0; c < 40 && (idx < 8 || sb.size() > 0); c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (idx < 8);
            @(negedge clk);
            if (c >= 3 && c <= 6) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_in_ready_c%0d: got %b, expected 0", c, in_ready);
                end
            end
            if (in_valid && in_ready) begin
                idx++;
                a = $urandom; b = $urandom; sub = $urandom_range(0, 1);
            end
            @(posedge clk); #1;
        end
        drain(5);
        n_checks++;
        if (n_out - out0 != 8 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL bp_count: got %0d results (%0d pending), expected 8 (0 pending)",
                     n_out - out0, sb.size());
        end
    endtask

    task automatic test_random;
        logic [31:0] corner[4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        for (int c = 0; c < 60; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a   = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            b   = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            sub = $urandom_range(0, 1);
            @(posedge clk); #1;
        end
        drain(20);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rand_drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b0; in_valid = 1'b1;
        a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0;
        @(posedge clk); #1;
        a = 32'hDEAD_BEEF; b = 32'h0000_0001; sub = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_full: got ov=%b ir=%b, expected ov=1 ir=0", out_valid, in_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || sum !== 32'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: got ov=%b sum=%h ir=%b, expected ov=0 sum=0 ir=1",
                     out_valid, sum, in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_stale_%0d: got ov=%b, expected 0", i, out_valid);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
